// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/LSB request, response and byte-RAM signals of the memory arbiter
interface mem_arbiter_if;
  logic        if_to_mc_enable;
  logic [31:0] if_to_mc_addr;
  logic        mc_to_if_done;
  logic [31:0] mc_to_if_val;

  logic        lsb_to_mc_enable;
  logic        lsb_to_mc_wr;
  logic [1:0]  lsb_to_mc_ls_type;
  logic [31:0] lsb_to_mc_addr;
  logic [31:0] lsb_to_mc_st_val;
  logic        mc_to_lsb_ld_done;
  logic        mc_to_lsb_st_done;
  logic [31:0] mc_to_lsb_ld_val;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    input  if_to_mc_enable, if_to_mc_addr,
    input  lsb_to_mc_enable, lsb_to_mc_wr, lsb_to_mc_ls_type, lsb_to_mc_addr, lsb_to_mc_st_val,
    input  mem_din, io_buffer_full,
    output mc_to_if_done, mc_to_if_val,
    output mc_to_lsb_ld_done, mc_to_lsb_st_done, mc_to_lsb_ld_val,
    output mem_dout, mem_a, mem_wr
  );

  modport slave (
    output if_to_mc_enable, if_to_mc_addr,
    output lsb_to_mc_enable, lsb_to_mc_wr, lsb_to_mc_ls_type, lsb_to_mc_addr, lsb_to_mc_st_val,
    output mem_din, io_buffer_full,
    input  mc_to_if_done, mc_to_if_val,
    input  mc_to_lsb_ld_done, mc_to_lsb_st_done, mc_to_lsb_ld_val,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter serialising fetch and load/store words onto a byte-wide RAM
module mem_arbiter #(
  parameter logic [31:0] IO_ADDR_BASE = 32'h30000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          clr,
  mem_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, IF_READ, LS_READ, LS_WRITE, DONE} state_e;

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [1:0]  nlast_q;
  logic        rd_vld_q;
  logic        last_lsb_q;
  logic [31:0] data_q;
  logic [31:0] mem_a_q;
  logic [7:0]  mem_dout_q;
  logic        mem_wr_q;
  logic        if_done_q;
  logic        ld_done_q;
  logic        st_done_q;
  logic [31:0] if_val_q;
  logic [31:0] ld_val_q;

  logic        lsb_blocked;
  logic        if_elig;
  logic        lsb_elig;
  logic        pick_lsb;
  logic        rd_last;
  logic        more_addr;
  logic [1:0]  req_nlast;
  logic [1:0]  cnt_inc;
  logic [2:0]  issued;
  logic [31:0] rd_data_d;
  logic [7:0]  wr_byte_d;

  always_comb begin
    lsb_blocked = bus.lsb_to_mc_wr && (bus.lsb_to_mc_addr >= IO_ADDR_BASE) && bus.io_buffer_full;
    if_elig     = bus.if_to_mc_enable && !clr;
    // A flush kills speculative reads but a store is already committed.
    lsb_elig    = bus.lsb_to_mc_enable && !lsb_blocked && (!clr || bus.lsb_to_mc_wr);
    pick_lsb    = lsb_elig && (!if_elig || !last_lsb_q);
    case (bus.lsb_to_mc_ls_type)
      2'd0:    req_nlast = 2'd0;
      2'd1:    req_nlast = 2'd1;
      default: req_nlast = 2'd3;
    endcase
    cnt_inc   = cnt_q + 2'd1;
    // Reads run one cycle behind their address: issued = bytes addressed so far minus one.
    issued    = {1'b0, cnt_q} + {2'b00, rd_vld_q};
    more_addr = issued < {1'b0, nlast_q};
    rd_last   = rd_vld_q && (cnt_q == nlast_q);
    rd_data_d = data_q | ({24'd0, bus.mem_din} << {cnt_q, 3'b000});
    wr_byte_d = bus.lsb_to_mc_st_val[{cnt_inc, 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      nlast_q    <= 2'd0;
      rd_vld_q   <= 1'b0;
      last_lsb_q <= 1'b0;
      data_q     <= 32'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ld_done_q  <= 1'b0;
      st_done_q  <= 1'b0;
      if_val_q   <= 32'd0;
      ld_val_q   <= 32'd0;
    end else if (rdy) begin
      if_done_q <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q    <= 2'd0;
          rd_vld_q <= 1'b0;
          if (pick_lsb) begin
            last_lsb_q <= 1'b1;
            mem_a_q    <= bus.lsb_to_mc_addr;
            nlast_q    <= req_nlast;
            data_q     <= 32'd0;
            if (bus.lsb_to_mc_wr) begin
              state_q    <= LS_WRITE;
              mem_wr_q   <= 1'b1;
              mem_dout_q <= bus.lsb_to_mc_st_val[7:0];
            end else begin
              state_q <= LS_READ;
            end
          end else if (if_elig) begin
            last_lsb_q <= 1'b0;
            mem_a_q    <= bus.if_to_mc_addr;
            nlast_q    <= 2'd3;
            data_q     <= 32'd0;
            state_q    <= IF_READ;
          end
        end
        IF_READ, LS_READ: begin
          if (clr) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            rd_vld_q <= 1'b0;
            mem_a_q  <= 32'd0;
          end else begin
            rd_vld_q <= 1'b1;
            if (more_addr) mem_a_q <= mem_a_q + 32'd1;
            if (rd_vld_q) begin
              data_q <= rd_data_d;
              cnt_q  <= cnt_inc;
            end
            if (rd_last) begin
              state_q  <= DONE;
              cnt_q    <= 2'd0;
              rd_vld_q <= 1'b0;
              mem_a_q  <= 32'd0;
              if (state_q == IF_READ) begin
                if_done_q <= 1'b1;
                if_val_q  <= rd_data_d;
              end else begin
                ld_done_q <= 1'b1;
                ld_val_q  <= rd_data_d;
              end
            end
          end
        end
        LS_WRITE: begin
          if (cnt_q == nlast_q) begin
            state_q    <= DONE;
            cnt_q      <= 2'd0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= 8'd0;
            mem_a_q    <= 32'd0;
            st_done_q  <= 1'b1;
          end else begin
            cnt_q      <= cnt_inc;
            mem_a_q    <= mem_a_q + 32'd1;
            mem_dout_q <= wr_byte_d;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_a             = mem_a_q;
  assign bus.mem_dout          = mem_dout_q;
  assign bus.mem_wr            = mem_wr_q;
  assign bus.mc_to_if_done     = if_done_q;
  assign bus.mc_to_if_val      = if_val_q;
  assign bus.mc_to_lsb_ld_done = ld_done_q;
  assign bus.mc_to_lsb_st_done = st_done_q;
  assign bus.mc_to_lsb_ld_val  = ld_val_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter IO_ADDR_BASE, default 32'h30000; addresses >= this are the I/O region.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high; rdy  in  1  global enable; clr  in  1  pipeline flush.
REQ-003 SHALL have ports: if_to_mc_enable  in  1  fetch request (level); if_to_mc_addr  in  32  fetch address.
REQ-004 SHALL have ports: mc_to_if_done  out  1  fetch-complete pulse; mc_to_if_val  out  32  fetched word.
REQ-005 SHALL have ports: lsb_to_mc_enable  in  1  LSB request (level); lsb_to_mc_wr  in  1  1=write; lsb_to_mc_ls_type  in  2  0=byte, 1=half, 2=word; lsb_to_mc_addr  in  32; lsb_to_mc_st_val  in  32.
REQ-006 SHALL have ports: mc_to_lsb_ld_done  out  1; mc_to_lsb_st_done  out  1; mc_to_lsb_ld_val  out  32  zero-extended load data.
REQ-007 SHALL have ports: mem_din  in  8  RAM read byte; mem_dout  out  8; mem_a  out  32; mem_wr  out  1  1=write; io_buffer_full  in  1.

Function
REQ-008 SHALL implement FSM states IDLE, IF_READ, LS_READ, LS_WRITE, DONE, with a 2-bit byte counter.
REQ-009 SHALL treat requests as level-held: requester keeps enable and arguments stable until its done pulse.
REQ-010 In IDLE with exactly one eligible request, SHALL grant it at that clock edge.
REQ-011 With both requests eligible, SHALL grant round-robin: the requester not granted last wins. last_grant resets to IF, so LSB wins the first tie.
REQ-012 An LSB write with addr >= IO_ADDR_BASE SHALL be ineligible while io_buffer_full=1; a pending fetch may be granted meanwhile.
REQ-013 Byte count SHALL be N=1/2/4 for ls_type 0/1/2; a fetch is always N=4.
REQ-014 Byte k SHALL use address addr+k, little-endian (byte k occupies bits 8k+7:8k).
REQ-015 Read timing, grant in cycle G: mem_a=addr+k in cycle G+1+k; mem_din carries byte k in cycle G+2+k; done high in cycle G+N+2.
REQ-016 Write timing, grant in cycle G: mem_a=addr+k, mem_dout=st_val byte k, mem_wr=1 in cycle G+1+k; mem_st_done high in cycle G+N+1.
REQ-017 mem_wr SHALL be 0 in every cycle that is not an active write byte; mem_a SHALL be 0 when IDLE.
REQ-018 Upper bytes of mc_to_lsb_ld_val beyond N SHALL be 0; sign extension belongs to the LSB.
REQ-019 Each done SHALL be a 1-cycle pulse emitted from state DONE; DONE SHALL always return to IDLE, and no new grant is possible in the DONE cycle (prevents re-accepting a stale enable).
REQ-020 Result values SHALL remain valid at least during the done cycle.
REQ-021 clr=1 in IF_READ or LS_READ SHALL abort: return to IDLE at that edge, no done pulse, counter cleared.
REQ-022 clr SHALL NOT affect LS_WRITE (committed stores complete) or DONE.
REQ-023 In IDLE with clr=1, SHALL grant only an LSB write; reads are not granted that cycle.
REQ-024 With rdy=0, all state and outputs SHALL hold; rst has priority over rdy.
REQ-025 Address arithmetic SHALL be 32-bit modulo 2^32.

Reset
REQ-026 On rst=1 at a clock edge, SHALL enter IDLE, clear the counter, set last_grant=IF, and set all outputs to 0 (mem_wr=0, mem_a=0, mem_dout=0, done pulses 0, values 0).
REQ-027 rst mid-transfer SHALL abandon the transfer silently, emit no done pulse, and not resume.

Verification
REQ-028 Fetch 0x100, RAM bytes 13,05,10,00 -> mc_to_if_val=0x00100513; mc_to_if_done single pulse in G+6.
REQ-029 LH 0x202, RAM EF,BE -> mc_to_lsb_ld_val=0x0000BEEF; ld_done in G+4.
REQ-030 SW 0xDEADBEEF @0x400 -> writes EF,BE,AD,DE to 0x400..0x403 in G+1..G+4, mem_wr=1 only those cycles; st_done in G+5.
REQ-031 Both requesters high from IDLE after reset -> LSB served first, then fetch; next tie -> LSB ignored until fetch completes.
REQ-032 clr during fetch byte 2 -> no done, IDLE next cycle, mem_wr stays 0; clr during SW byte 1 -> all 4 bytes written, st_done pulses.
REQ-033 SB 0x30000 with io_buffer_full=1 and fetch pending -> fetch served, no write; io_buffer_full falls -> single byte written, st_done.
